// File: rtl/serial_adder_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl_if
// Request/result bundle between an add requester and serial_adder_ctrl.
//   Start       : request pulse, honoured only while the controller is idle
//   A, B, Cin   : operands and carry-in, captured when Start is accepted
//   Busy        : high while bits are being processed
//   Done        : one-cycle completion pulse, Sum/Cout valid
//   Sum, Cout   : result register and carry out of the top bit
// master = requester side, slave = controller side.
// ---------------------------------------------------------------------------
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;

    modport master (
        output Start, A, B, Cin,
        input  Busy, Done, Sum, Cout
    );

    modport slave (
        input  Start, A, B, Cin,
        output Busy, Done, Sum, Cout
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial adder: a single full-adder cell (two half adders) is stepped
// LSB-first across a WIDTH-bit operand pair, one bit per clock.
//   Clk  : rising-edge clock
//   Rst  : synchronous, active-high reset
//   bus  : serial_adder_ctrl_if.slave (Start/A/B/Cin in, Busy/Done/Sum/Cout out)
// Latency from accepted Start to Done is WIDTH+1 edges; Sum/Cout update only
// on the final bit's edge and otherwise hold the previous result.
// ---------------------------------------------------------------------------
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                Clk,
    input  logic                Rst,
    serial_adder_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh, b_sh, acc, sum_q;
    logic             carry, cout_q;
    logic [CW-1:0]    cnt;

    logic s1, c1, s, c2, carry_nxt, last_bit;
    logic [WIDTH-1:0] acc_nxt;

    // Shared full-adder cell, built from two half adders.
    always_comb begin
        s1        = a_sh[0] ^ b_sh[0];
        c1        = a_sh[0] & b_sh[0];
        s         = s1 ^ carry;
        c2        = s1 & carry;
        carry_nxt = c1 | c2;
        acc_nxt   = {s, acc[WIDTH-1:1]};
        last_bit  = (cnt == CW'(WIDTH - 1));
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, exactly like the flops being described.
    always_ff @(posedge Clk) begin
        if (Rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: the default assignment first guarantees state_d is written on
    // every path, so no latch is inferred for unlisted states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.Start) state_d = RUN;
            RUN:     if (last_bit)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.Start) begin
                        a_sh  <= bus.A;
                        b_sh  <= bus.B;
                        carry <= bus.Cin;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= carry_nxt;
                    acc   <= acc_nxt;
                    cnt   <= cnt + CW'(1);
                    // Result is published only on the final bit, so Sum/Cout
                    // keep the previous result for the whole operation.
                    if (last_bit) begin
                        sum_q  <= acc_nxt;
                        cout_q <= carry_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Busy = (state_q == RUN);
    assign bus.Done = (state_q == DONE);
    assign bus.Sum  = sum_q;
    assign bus.Cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl
// Scoreboard bench: each issued add pushes its arithmetic result
// (A+B+Cin as a WIDTH+1-bit value) into a queue; a monitor pops and compares
// whenever Done is seen.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [W:0] exp_q[$];
    int         done_cycs[$];
    logic [W:0] prev_res = '0;

    always @(posedge Clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each completion against the scoreboard.
    always @(negedge Clk) begin
        if (!Rst && bus.Done === 1'b1) begin
            done_cycs.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                check("result", {55'd0, bus.Cout, bus.Sum}, {55'd0, exp_q.pop_front()});
            end
        end
    end

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    endfunction

    // Issue one add, check Busy length, result hold and the Done pulse width.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        int busy_n;
        bit seen;
        logic [W:0] exp;
        exp = model(a, b, ci);
        exp_q.push_back(exp);
        @(negedge Clk);
        bus.A = a; bus.B = b; bus.Cin = ci; bus.Start = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;
        bus.A = W'($urandom); bus.B = W'($urandom); bus.Cin = 1'($urandom);
        busy_n = 0;
        seen   = 0;
        for (int k = 0; k < W + 4 && !seen; k++) begin
            if (bus.Done) begin
                seen = 1;
            end else begin
                if (bus.Busy) busy_n++;
                check("sum_hold", {55'd0, bus.Cout, bus.Sum}, {55'd0, prev_res});
                @(negedge Clk);
            end
        end
        check("done_seen", 64'(seen), 64'd1);
        check("busy_cycles", 64'(busy_n), 64'(W));
        @(negedge Clk);
        check("done_one_cycle", {63'd0, bus.Done}, 64'd0);
        check("idle_after", {63'd0, bus.Busy}, 64'd0);
        prev_res = exp;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] ra, rb;
        int base;

        // Reset held 2 cycles with Start high: nothing may start.
        bus.Start = 1'b1; bus.A = 8'h12; bus.B = 8'h34; bus.Cin = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst_busy", {63'd0, bus.Busy}, 64'd0);
        check("rst_done", {63'd0, bus.Done}, 64'd0);
        check("rst_sum",  {56'd0, bus.Sum},  64'd0);
        check("rst_cout", {63'd0, bus.Cout}, 64'd0);
        Rst = 1'b0; bus.Start = 1'b0;
        @(negedge Clk);
        check("rst_no_start", {63'd0, bus.Busy}, 64'd0);

        // Directed adds.
        run_op(8'h5A, 8'h3C, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1);

        // Start pulses during RUN and DONE must be ignored.
        exp_q.push_back(model(8'h10, 8'h20, 1'b0));
        base = done_cycs.size();
        @(negedge Clk);
        bus.A = 8'h10; bus.B = 8'h20; bus.Cin = 1'b0; bus.Start = 1'b1;
        for (int k = 1; k <= W + 4; k++) begin
            @(negedge Clk);
            bus.Start = 1'b0;
            if (k == 3)     begin bus.Start = 1'b1; bus.A = 8'h01; bus.B = 8'h01; end
            if (k == W + 1) begin
                check("done_in_ignore", {63'd0, bus.Done}, 64'd1);
                bus.Start = 1'b1;
            end
        end
        check("ignore_busy", {63'd0, bus.Busy}, 64'd0);
        check("ignore_one_done", 64'(done_cycs.size() - base), 64'd1);
        prev_res = model(8'h10, 8'h20, 1'b0);

        // Reset in the middle of an operation discards it.
        @(negedge Clk);
        bus.A = 8'hAA; bus.B = 8'h55; bus.Cin = 1'b0; bus.Start = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        check("midrst_busy", {63'd0, bus.Busy}, 64'd0);
        check("midrst_sum", {55'd0, bus.Cout, bus.Sum}, 64'd0);
        Rst = 1'b0;
        prev_res = '0;
        repeat (W + 3) @(negedge Clk);
        check("midrst_no_done", 64'(exp_q.size()), 64'd0);
        run_op(8'h03, 8'h04, 1'b0);

        // Back-to-back with Start held high.
        exp_q.push_back(model(8'h80, 8'h80, 1'b0));
        exp_q.push_back(model(8'h7F, 8'h00, 1'b1));
        base = done_cycs.size();
        @(negedge Clk);
        bus.A = 8'h80; bus.B = 8'h80; bus.Cin = 1'b0; bus.Start = 1'b1;
        @(negedge Clk);
        bus.A = 8'h7F; bus.B = 8'h00; bus.Cin = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            #1;
            if (done_cycs.size() >= base + 2) break;
        end
        bus.Start = 1'b0;
        if (done_cycs.size() >= base + 2) begin
            check("b2b_spacing", 64'(done_cycs[base + 1] - done_cycs[base]), 64'(W + 2));
        end else begin
            check("b2b_two_done", 64'(done_cycs.size() - base), 64'd2);
        end
        repeat (3) @(negedge Clk);
        check("b2b_idle", {63'd0, bus.Busy}, 64'd0);
        prev_res = model(8'h7F, 8'h00, 1'b1);

        // Random operands against the arithmetic model.
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, 1'($urandom));
        end

        repeat (4) @(negedge Clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
